// File: rtl/freq_gen.sv
// freq_gen: phase-accumulator square-wave generator, continuous or N-period burst.
// Latency: sig_out registered, first valid 1 clk after RUN entry; RUN-time cfg applies at the next wrap.
// Backpressure: cfg_ready=1 in IDLE, !pend in RUN (one shadow slot), 0 in DONE.
module freq_gen #(
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16,
  parameter int CLK_HZ = 200_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_fword,
  input  logic [ACC_W-1:0] cfg_duty,
  input  logic [CNT_W-1:0] cfg_burst,
  input  logic             start,
  input  logic             stop,
  output logic             sig_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // CLK_HZ only documents the output frequency formula; a non-positive value
  // marks an unconfigured instance, which never leaves IDLE.
  localparam bit LP_CLK_OK = (CLK_HZ > 0);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_fword_act;
  logic [ACC_W-1:0] r_duty_act;
  logic [CNT_W-1:0] r_burst_act;
  logic [ACC_W-1:0] r_fword_sh;
  logic [ACC_W-1:0] r_duty_sh;
  logic             r_pend;
  logic             r_stop_pend;
  logic             r_sig;
  logic [CNT_W-1:0] r_cnt;

  logic             w_idle;
  logic             w_run;
  logic [ACC_W:0]   w_sum;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_burst_hit;
  logic             w_start_ok;
  logic             w_term;
  logic             w_cfg_fire;
  logic             w_apply;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_run       = (r_state == ST_RUN);

  // One extra bit on the adder: its carry is the period boundary.
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_fword_act};
  assign w_wrap      = w_sum[ACC_W];
  assign w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // Burst ends on the wrap that completes the burst_act-th period.
  assign w_burst_hit = (r_burst_act != '0) && (w_cnt_inc == r_burst_act);

  // A zero increment would never wrap, so such a start is dropped.
  assign w_start_ok  = LP_CLK_OK && w_idle && start && (r_fword_act != '0);

  // Termination is only ever taken at a period boundary, so the last period is whole.
  assign w_term      = w_run && w_wrap && (w_burst_hit || r_stop_pend || stop);

  assign w_cfg_fire  = cfg_valid && cfg_ready;

  // A shadow accepted in an earlier clk is promoted at a wrap, unless that
  // wrap ends the run (DONE discards it).
  assign w_apply     = w_run && w_wrap && r_pend && !w_term;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_term)     w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs: handshake ready, busy flag, done pulse.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
      end
      ST_RUN: begin
        cfg_ready = !r_pend;
        busy      = 1'b1;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
      end
    endcase
  end

  // Phase accumulator, registered square wave and completed-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sig <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_acc <= '0;
            r_sig <= 1'b0;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          // Compare uses the pre-increment phase, so acc=0 gives the first high clk.
          r_acc <= w_sum[ACC_W-1:0];
          r_sig <= (r_acc < r_duty_act);
          if (w_wrap) begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_DONE: begin
          r_sig <= 1'b0;
        end
        default: begin
          r_sig <= 1'b0;
        end
      endcase
    end
  end

  // Active and shadow configuration; the accumulator is never cleared on an
  // update, so a frequency change keeps phase continuity and emits no runt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fword_act <= '0;
      r_duty_act  <= '0;
      r_burst_act <= '0;
      r_fword_sh  <= '0;
      r_duty_sh   <= '0;
      r_pend      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_fire) begin
            r_fword_act <= cfg_fword;
            r_duty_act  <= cfg_duty;
            r_burst_act <= cfg_burst;
          end
          r_pend <= 1'b0;
        end
        ST_RUN: begin
          // cfg_ready is !r_pend here, so an accept and an apply never coincide;
          // an accept on a wrap clk waits for the following wrap.
          if (w_cfg_fire) begin
            r_fword_sh <= cfg_fword;
            r_duty_sh  <= cfg_duty;
            r_pend     <= 1'b1;
          end else if (w_apply) begin
            r_fword_act <= r_fword_sh;
            r_duty_act  <= r_duty_sh;
            r_pend      <= 1'b0;
          end
        end
        ST_DONE: begin
          r_pend <= 1'b0;
        end
        default: begin
          r_pend <= 1'b0;
        end
      endcase
    end
  end

  // Stop request latch: a stop between wraps is held until the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_stop_pend <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop && !w_wrap) begin
            r_stop_pend <= 1'b1;
          end
        end
        default: begin
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

  assign sig_out   = r_sig;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed stimulus for freq_gen (ACC_W=8), expected waveform events queued at issue.
// A negedge monitor turns sig_out edges and done pulses into events and checks them in order.
// Direct status checks cover reset, handshake hold-off and busy/cycle_cnt after completion.
`timescale 1ns/1ps
module tb_freq_gen;

  localparam int ACC_W = 8;
  localparam int CNT_W = 16;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_fword = '0;
  logic [ACC_W-1:0] cfg_duty = '0;
  logic [CNT_W-1:0] cfg_burst = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             sig_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;

  freq_gen #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_fword (cfg_fword),
    .cfg_duty  (cfg_duty),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .sig_out   (sig_out),
    .busy      (busy),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Count of posedges seen; stable when read at a negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // n periods of length p with h high clocks; first rise one clk after RUN entry t0.
  task automatic push_wave(input int t0, input int p, input int h, input int n, input int cnt0);
    for (int k = 0; k < n; k++) begin
      push(EV_RISE, t0 + 1 + p * k, cnt0 + k);
      push(EV_FALL, t0 + 1 + h + p * k, cnt0 + k);
    end
  endtask

  task automatic report(input int kind, input int c, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d cnt=%0d want none", kind, c, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != c || e.val != v) begin
        bad++;
        $display("FAIL event: got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                 kind, c, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: each sig_out edge or done pulse is an output event.
  logic prev_sig = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sig = sig_out;
    end else begin
      if (sig_out !== prev_sig) report(sig_out ? EV_RISE : EV_FALL, cyc, int'(cycle_cnt));
      prev_sig = sig_out;
      if (done === 1'b1) report(EV_DONE, cyc, int'(cycle_cnt));
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic cfg_idle(input int fw, input int du, input int bu);
    cfg_valid = 1'b1;
    cfg_fword = ACC_W'(fw);
    cfg_duty  = ACC_W'(du);
    cfg_burst = CNT_W'(bu);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_cfg_run(input int fw, input int du, output int acc_cyc);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_fword = ACC_W'(fw);
    cfg_duty  = ACC_W'(du);
    cfg_burst = '0;
    while (!cfg_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      total++;
      bad++;
      $display("FAIL cfg_handshake_timeout: cfg_ready=%0b want 1", cfg_ready);
    end
    acc_cyc = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Returns t0, the posedge index at which the DUT enters RUN.
  task automatic start_run(output int t0);
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop_at(input int n);
    at_cyc(n);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int a;
    int b;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_sig_out", sig_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Continuous 16-clk periods (8/8), stop 3 clk into the 4th period.
    cfg_idle(16, 128, 0);
    start_run(t0);
    push_wave(t0, 16, 8, 4, 0);
    push(EV_DONE, t0 + 64, 4);
    at_cyc(t0 + 10);
    chk("t1_busy_run", busy, 1);
    chk("t1_cfg_ready_run", cfg_ready, 1);
    pulse_stop_at(t0 + 50);
    at_cyc(t0 + 63);
    chk("t1_busy_before_wrap", busy, 1);
    at_cyc(t0 + 65);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_after", done, 0);

    // Burst of 3 periods of 8 clk (2/6).
    cfg_idle(32, 64, 3);
    start_run(t0);
    push_wave(t0, 8, 2, 3, 0);
    push(EV_DONE, t0 + 24, 3);
    at_cyc(t0 + 25);
    chk("t2_sig_out_end", sig_out, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_cycle_cnt_end", cycle_cnt, 3);

    // Mid-period reconfiguration to 4-clk periods; applies at the next wrap.
    cfg_idle(16, 128, 0);
    start_run(t0);
    push_wave(t0, 16, 8, 2, 0);
    push_wave(t0 + 32, 4, 2, 4, 2);
    push(EV_DONE, t0 + 48, 6);
    at_cyc(t0 + 19);
    send_cfg_run(64, 128, a);
    chk("t3_accept_cyc", a, t0 + 19);
    at_cyc(t0 + 25);
    chk("t3_cfg_ready_pend_a", cfg_ready, 0);
    at_cyc(t0 + 31);
    chk("t3_cfg_ready_pend_b", cfg_ready, 0);
    at_cyc(t0 + 32);
    chk("t3_cfg_ready_applied", cfg_ready, 1);
    pulse_stop_at(t0 + 47);
    at_cyc(t0 + 50);
    chk("t3_busy_end", busy, 0);

    // Stop coincident with a wrap ends at that same wrap.
    cfg_idle(16, 128, 0);
    start_run(t0);
    push_wave(t0, 16, 8, 2, 0);
    push(EV_DONE, t0 + 32, 2);
    pulse_stop_at(t0 + 31);
    at_cyc(t0 + 33);
    chk("t4_busy_end", busy, 0);
    chk("t4_cycle_cnt_end", cycle_cnt, 2);

    // Back-to-back RUN configs: second held off until the first applies.
    cfg_idle(16, 128, 0);
    start_run(t0);
    push(EV_RISE, t0 + 1, 0);
    push(EV_FALL, t0 + 9, 0);
    push(EV_RISE, t0 + 17, 1);
    push(EV_FALL, t0 + 19, 1);
    push(EV_RISE, t0 + 25, 2);
    push(EV_FALL, t0 + 27, 2);
    push(EV_RISE, t0 + 29, 3);
    push(EV_FALL, t0 + 31, 3);
    push(EV_DONE, t0 + 32, 4);
    at_cyc(t0 + 4);
    send_cfg_run(32, 64, a);
    chk("t6_first_accept", a, t0 + 4);
    send_cfg_run(64, 128, b);
    chk("t6_second_accept", b, t0 + 16);
    pulse_stop_at(t0 + 31);
    at_cyc(t0 + 34);
    chk("t6_busy_end", busy, 0);

    // duty=0: constant low; one-period burst.
    cfg_idle(16, 0, 1);
    start_run(t0);
    push(EV_DONE, t0 + 16, 1);
    at_cyc(t0 + 18);
    chk("duty0_busy_end", busy, 0);

    // duty above every reached phase: constant high until DONE.
    cfg_idle(16, 255, 1);
    start_run(t0);
    push(EV_RISE, t0 + 1, 0);
    push(EV_DONE, t0 + 16, 1);
    push(EV_FALL, t0 + 17, 1);
    at_cyc(t0 + 19);
    chk("dutymax_busy_end", busy, 0);

    // fword=0: start ignored.
    cfg_idle(0, 128, 0);
    start_run(t0);
    at_cyc(t0 + 3);
    chk("t5_fword0_busy", busy, 0);
    chk("t5_fword0_sig", sig_out, 0);

    // Reset mid-RUN clears outputs at once.
    cfg_idle(16, 128, 0);
    start_run(t0);
    push(EV_RISE, t0 + 1, 0);
    push(EV_FALL, t0 + 9, 0);
    push(EV_RISE, t0 + 17, 1);
    at_cyc(t0 + 20);
    chk("t5_busy_pre_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sig_out", sig_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cycle_cnt", cycle_cnt, 0);
    chk("t5_rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset also cleared the active fword, so start is ignored.
    start_run(t0);
    at_cyc(t0 + 2);
    chk("t5_post_reset_start_ignored", busy, 0);

    repeat (4) @(negedge clk);
    chk("events_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
